// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// Imported by the interface, the wait counter and the arbiter top.
package wb_arb_pkg;

    localparam int DW_DEF       = 32;
    localparam int AW_DEF       = 5;
    localparam int MAX_WAIT_DEF = 4;
    localparam int REG_ZERO     = 0;

    typedef enum logic {
        ST_PIPE,
        ST_FORCE
    } arb_state_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-port bundle: S3 writeback request, MCU valid/ready result
// channel and the registered register-file write port.
import wb_arb_pkg::*;

interface wb_port_arbiter_if #(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
);
    logic          pipe_we;
    logic [AW-1:0] pipe_sel;
    logic [DW-1:0] pipe_data;
    logic          mc_valid;
    logic [AW-1:0] mc_sel;
    logic [DW-1:0] mc_data;
    logic          mc_ready;
    logic          pipe_stall;
    logic          rf_we;
    logic [AW-1:0] rf_sel;
    logic [DW-1:0] rf_data;
    logic          mc_drop;

    modport master (
        output pipe_we, pipe_sel, pipe_data,
        output mc_valid, mc_sel, mc_data,
        input  mc_ready, pipe_stall,
        input  rf_we, rf_sel, rf_data, mc_drop
    );

    modport slave (
        input  pipe_we, pipe_sel, pipe_data,
        input  mc_valid, mc_sel, mc_data,
        output mc_ready, pipe_stall,
        output rf_we, rf_sel, rf_data, mc_drop
    );
endinterface

// File: rtl/wb_arb_sat_counter.sv
// Saturating count of consecutive cycles an MCU result was blocked.
// Clear takes priority over increment.
import wb_arb_pkg::*;

module wb_arb_sat_counter #(
    parameter  int MAX = MAX_WAIT_DEF,
    localparam int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          at_max
);
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign at_max = (cnt_q == CW'(MAX));
    assign cnt    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between S3 writeback and the MCU,
// with starvation forcing and same-register conflict resolution.
import wb_arb_pkg::*;

module wb_port_arbiter #(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    arb_state_e    state_q, state_d;
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_sel_q, rf_sel_d;
    logic [DW-1:0] rf_data_q, rf_data_d;
    logic          mc_drop_q, mc_drop_d;

    logic          preq, mreq, mzero, same_sel;
    logic          grant_pipe, grant_mc;
    logic          mc_ready_c, pipe_stall_c;
    logic          cnt_inc, cnt_clr;
    logic [CW-1:0] cnt;
    logic          at_max, near_max;

    assign preq     = bus.pipe_we && (bus.pipe_sel != AW'(REG_ZERO));
    assign mreq     = bus.mc_valid && (bus.mc_sel != AW'(REG_ZERO));
    assign mzero    = bus.mc_valid && (bus.mc_sel == AW'(REG_ZERO));
    assign same_sel = (bus.pipe_sel == bus.mc_sel);
    // This blocked cycle is the MAX_WAIT-th in a row.
    assign near_max = at_max || (cnt == CW'(MAX_WAIT - 1));

    wb_arb_sat_counter #(
        .MAX (MAX_WAIT)
    ) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (cnt_inc),
        .clr    (cnt_clr),
        .cnt    (cnt),
        .at_max (at_max)
    );

    always_comb begin
        state_d      = ST_PIPE;
        grant_pipe   = 1'b0;
        grant_mc     = 1'b0;
        mc_ready_c   = 1'b0;
        pipe_stall_c = 1'b0;
        mc_drop_d    = 1'b0;
        cnt_inc      = 1'b0;
        cnt_clr      = 1'b0;
        unique case (state_q)
            ST_PIPE: begin
                if (mzero) begin
                    mc_ready_c = 1'b1;
                    cnt_clr    = 1'b1;
                    grant_pipe = preq;
                end else if (mreq && preq) begin
                    grant_pipe = 1'b1;
                    if (same_sel) begin
                        // Older MCU value would be overwritten anyway.
                        mc_ready_c = 1'b1;
                        mc_drop_d  = 1'b1;
                        cnt_clr    = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                        if (near_max) begin
                            state_d = ST_FORCE;
                        end
                    end
                end else if (mreq) begin
                    grant_mc   = 1'b1;
                    mc_ready_c = 1'b1;
                    cnt_clr    = 1'b1;
                end else begin
                    grant_pipe = preq;
                end
            end
            ST_FORCE: begin
                cnt_clr = 1'b1;
                if (mreq) begin
                    grant_mc     = 1'b1;
                    mc_ready_c   = 1'b1;
                    pipe_stall_c = preq;
                end else if (mzero) begin
                    mc_ready_c = 1'b1;
                    grant_pipe = preq;
                end else begin
                    pipe_stall_c = preq;
                end
            end
            default: begin
                state_d = ST_PIPE;
            end
        endcase
        if (rst) begin
            mc_ready_c   = 1'b0;
            pipe_stall_c = 1'b0;
        end
    end

    always_comb begin
        rf_we_d   = 1'b0;
        rf_sel_d  = rf_sel_q;
        rf_data_d = rf_data_q;
        if (grant_mc) begin
            rf_we_d   = 1'b1;
            rf_sel_d  = bus.mc_sel;
            rf_data_d = bus.mc_data;
        end else if (grant_pipe) begin
            rf_we_d   = 1'b1;
            rf_sel_d  = bus.pipe_sel;
            rf_data_d = bus.pipe_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_PIPE;
            rf_we_q   <= 1'b0;
            rf_sel_q  <= '0;
            rf_data_q <= '0;
            mc_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rf_we_q   <= rf_we_d;
            rf_sel_q  <= rf_sel_d;
            rf_data_q <= rf_data_d;
            mc_drop_q <= mc_drop_d;
        end
    end

    assign bus.mc_ready   = mc_ready_c;
    assign bus.pipe_stall = pipe_stall_c;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_sel     = rf_sel_q;
    assign bus.rf_data    = rf_data_q;
    assign bus.mc_drop    = mc_drop_q;
endmodule
